// File: rtl/regfile.sv
// Integer register file: two combinational operand-read ports with write-through bypass,
// one write-back port, a registered req/ack debug read port and a committed-write counter.
module regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic [WCNT_W-1:0] wr_cnt
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StResp} dbg_state_e;

  logic [DATA_W-1:0] mem_q [NumRegs];
  logic [WCNT_W-1:0] wr_cnt_q;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  dbg_state_e        state_q, state_d;
  logic              commit;
  logic [DATA_W-1:0] dbg_rd;

  assign commit = rst_n && we && (waddr != '0);

  // Shared read rule for both operand ports and the debug capture.
  function automatic logic [DATA_W-1:0] read_val(
    input logic              rst_ok,
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (!rst_ok || !en || (addr == '0)) begin
      val = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    rdata1 = read_val(rst_n, re1, raddr1, we, waddr, wdata, mem_q[raddr1]);
    rdata2 = read_val(rst_n, re2, raddr2, we, waddr, wdata, mem_q[raddr2]);
    dbg_rd = read_val(rst_n, 1'b1, dbg_addr, we, waddr, wdata, mem_q[dbg_addr]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
    end else if (commit) begin
      wr_cnt_q <= wr_cnt_q + WCNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    dbg_data_d = dbg_data_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          dbg_data_d = dbg_rd;
          state_d    = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Ack is a decode of the registered state, so it is a clean one-cycle pulse.
  assign dbg_ack  = (state_q == StResp);
  assign dbg_data = dbg_data_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reads, bypass, x0 handling, debug port,
// reset during a debug response and write-counter wrap (counter narrowed to 4 bits).
module tb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WCNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_data;
  logic [WCNT_W-1:0] wr_cnt;

  int n_tests;
  int n_fail;

  regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .WCNT_W(WCNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .dbg_req (dbg_req),
    .dbg_addr(dbg_addr),
    .dbg_ack (dbg_ack),
    .dbg_data(dbg_data),
    .wr_cnt  (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; leave time 1 unit after the edge for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    we       = 1'b1;
    waddr    = 5'd3;
    wdata    = 32'hFFFF_0000;
    re1      = 1'b1;
    raddr1   = 5'd3;
    re2      = 1'b1;
    raddr2   = 5'd3;
    dbg_req  = 1'b0;
    dbg_addr = '0;
    #1;
    check("read_in_reset_p1", rdata1, 32'h0);
    check("read_in_reset_p2", rdata2, 32'h0);
    tick();
    tick();
    we    = 1'b0;
    rst_n = 1'b1;
    #1;
    // Write attempted during reset must not have landed
    check("reset_write_ignored", rdata1, 32'h0);
    check("reset_wr_cnt", {28'h0, wr_cnt}, 32'h0);
    check("reset_dbg_ack", {31'h0, dbg_ack}, 32'h0);
    check("reset_dbg_data", dbg_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      raddr1 = ADDR_W'(i);
      raddr2 = ADDR_W'(31 - i);
      #1;
      check($sformatf("reset_all_p1_x%0d", i), rdata1, 32'h0);
      check($sformatf("reset_all_p2_x%0d", 31 - i), rdata2, 32'h0);
    end

    // Same-cycle bypass then stored value
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; raddr1 = 5'd5; re1 = 1'b1;
    #1;
    check("bypass_x5", rdata1, 32'hDEAD_BEEF);
    check("cnt_before_commit", {28'h0, wr_cnt}, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("stored_x5", rdata1, 32'hDEAD_BEEF);
    check("cnt_after_x5", {28'h0, wr_cnt}, 32'h1);

    // Writes to x0 are dropped and not counted
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr2 = 5'd0; re2 = 1'b1;
    #1;
    check("x0_no_bypass", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("x0_stays_zero", rdata2, 32'h0);
    check("x0_not_counted", {28'h0, wr_cnt}, 32'h1);

    // Read enable gating and dual-port same entry
    re1 = 1'b0; raddr1 = 5'd5;
    #1;
    check("re1_off", rdata1, 32'h0);
    re1 = 1'b1; raddr2 = 5'd5;
    #1;
    check("dual_x5_p1", rdata1, 32'hDEAD_BEEF);
    check("dual_x5_p2", rdata2, 32'hDEAD_BEEF);
    re2 = 1'b0;
    #1;
    check("re2_off", rdata2, 32'h0);

    // Bypass only affects the matching port
    re2 = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_5A5A; raddr2 = 5'd7;
    #1;
    check("bypass_p2_x7", rdata2, 32'hA5A5_5A5A);
    check("no_bypass_p1_x5", rdata1, 32'hDEAD_BEEF);
    tick();
    we = 1'b0;
    #1;
    check("stored_x7", rdata2, 32'hA5A5_5A5A);
    check("cnt_after_x7", {28'h0, wr_cnt}, 32'h2);

    // Debug request held high: ack on alternate cycles
    dbg_addr = 5'd5; dbg_req = 1'b1;
    #1;
    check("dbg_c1_ack", {31'h0, dbg_ack}, 32'h0);
    tick();
    check("dbg_c2_ack", {31'h0, dbg_ack}, 32'h1);
    check("dbg_c2_data", dbg_data, 32'hDEAD_BEEF);
    tick();
    check("dbg_c3_ack", {31'h0, dbg_ack}, 32'h0);
    tick();
    check("dbg_c4_ack", {31'h0, dbg_ack}, 32'h1);
    dbg_req = 1'b0;
    tick();
    check("dbg_c5_ack", {31'h0, dbg_ack}, 32'h0);
    check("dbg_data_held", dbg_data, 32'hDEAD_BEEF);

    // Debug capture sees the same-cycle write
    dbg_addr = 5'd9; dbg_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h0BAD_F00D;
    tick();
    dbg_req = 1'b0; we = 1'b0;
    #1;
    check("dbg_bypass_ack", {31'h0, dbg_ack}, 32'h1);
    check("dbg_bypass_data", dbg_data, 32'h0BAD_F00D);
    check("cnt_after_x9", {28'h0, wr_cnt}, 32'h3);
    tick();

    dbg_addr = 5'd0; dbg_req = 1'b1;
    tick();
    dbg_req = 1'b0;
    check("dbg_x0_ack", {31'h0, dbg_ack}, 32'h1);
    check("dbg_x0_data", dbg_data, 32'h0);
    tick();

    // Reset landing in the RESP cycle
    dbg_addr = 5'd5; dbg_req = 1'b1;
    tick();
    check("dbg_pre_rst_ack", {31'h0, dbg_ack}, 32'h1);
    check("dbg_pre_rst_data", dbg_data, 32'hDEAD_BEEF);
    rst_n = 1'b0; dbg_req = 1'b0;
    #1;
    check("read_while_rst", rdata1, 32'h0);
    tick();
    check("rst_resp_ack", {31'h0, dbg_ack}, 32'h0);
    check("rst_resp_data", dbg_data, 32'h0);
    check("rst_resp_cnt", {28'h0, wr_cnt}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("x5_cleared", rdata1, 32'h0);
    tick();
    check("no_ack_owed", {31'h0, dbg_ack}, 32'h0);

    // 17 writes to x1 wrap the 4-bit counter to 1
    raddr1 = 5'd1;
    for (int i = 1; i <= 17; i++) begin
      we = 1'b1; waddr = 5'd1; wdata = 32'(i);
      tick();
      if (i == 15) begin
        check("cnt_at_15", {28'h0, wr_cnt}, 32'hF);
      end
      if (i == 16) begin
        check("cnt_wrap_0", {28'h0, wr_cnt}, 32'h0);
      end
    end
    we = 1'b0;
    #1;
    check("cnt_wrap_1", {28'h0, wr_cnt}, 32'h1);
    check("x1_last", rdata1, 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
